// File: rtl/hd_program_loader.sv
// hd_program_loader: copies an HD image into instruction memory; define LOADER_CHECKSUM_EN to add a checksum output
module hd_program_loader #(
   parameter int HD_AW      = 12,
   parameter int IM_AW      = 10,
   parameter int DW         = 32,
   parameter int HD_LATENCY = 1
) (
   input  logic             clock,
   input  logic             resetCPU,
   input  logic             start,
   input  logic [HD_AW-1:0] base_addr,
   input  logic [IM_AW:0]   length,
   input  logic [IM_AW-1:0] dest_addr,
   output logic [HD_AW-1:0] HDaddress,
   input  logic [DW-1:0]    HDIndata,
   output logic             IMwe,
   output logic [IM_AW-1:0] IMaddress,
   output logic [DW-1:0]    IMdata,
   output logic             busy,
   output logic             done,
`ifdef LOADER_CHECKSUM_EN
   output logic [DW-1:0]    checksum,
`endif
   output logic             error
);
   localparam int CW = $clog2(HD_LATENCY + 1);
   localparam logic [HD_AW:0] HD_SIZE = {1'b1, {HD_AW{1'b0}}};
   typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, WRITE, FIN} state_t;
   state_t st, nxt;
   logic [HD_AW-1:0] base_q;
   logic [IM_AW:0]   len_q;
   logic [IM_AW-1:0] dest_q;
   logic [IM_AW:0]   idx;
   logic [CW-1:0]    cnt;
   logic             range_bad;
   logic             last;
   assign range_bad = ({1'b0, base_q} + (HD_AW+1)'(len_q)) > HD_SIZE;
   assign last = (idx + 1'b1) == len_q;
   // state register
   always_ff @(posedge clock) st <= resetCPU ? IDLE : nxt;
   // next-state logic
   always_comb begin
      nxt = st;
      case (st)
         IDLE:    nxt = start ? CHECK : IDLE;
         CHECK:   nxt = (len_q == '0 || range_bad) ? FIN : REQ;
         REQ:     nxt = WAIT;
         WAIT:    nxt = (cnt == CW'(1)) ? WRITE : WAIT;
         WRITE:   nxt = last ? FIN : REQ;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // state-decoded outputs
   always_comb begin
      IMwe = st == WRITE;
      busy = st != IDLE;
      done = st == FIN;
   end
   // latched request, address/data registers, error and checksum
   always_ff @(posedge clock) begin
      if (resetCPU) begin
         base_q    <= '0;
         len_q     <= '0;
         dest_q    <= '0;
         idx       <= '0;
         cnt       <= '0;
         HDaddress <= '0;
         IMaddress <= '0;
         IMdata    <= '0;
         error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         if (st == IDLE && start) begin
            base_q <= base_addr;
            len_q  <= length;
            dest_q <= dest_addr;
            error  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
         end
         if (st == CHECK) begin
            error <= len_q != '0 && range_bad;
            idx   <= '0;
            if (nxt == REQ) HDaddress <= base_q;
         end
         if (st == REQ) cnt <= CW'(HD_LATENCY);
         if (st == WAIT) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               IMdata    <= HDIndata;
               IMaddress <= dest_q + idx[IM_AW-1:0];
            end
         end
         if (st == WRITE) begin
            idx <= idx + 1'b1;
            if (!last) HDaddress <= HDaddress + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum + IMdata;
`endif
         end
      end
   end
endmodule

// File: tb/tb_hd_program_loader.sv
// tb_hd_program_loader: randomized and directed checks of the loader at HD latencies 1 and 3
module tb_hd_program_loader;
   logic clock = 1'b0;
   logic resetCPU, start;
   logic [11:0] base_addr;
   logic [10:0] length;
   logic [9:0]  dest_addr;
   logic [11:0] hd_addr1, hd_addr3;
   logic [31:0] hd_in1, hd_in3, p1, p3a, p3b, p3c;
   logic        imwe1, imwe3, busy1, busy3, done1, done3, err1, err3;
   logic [9:0]  ima1, ima3;
   logic [31:0] imd1, imd3;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] cks1, cks3;
`endif
   logic [31:0] mem [4096];
   logic [41:0] q1[$], q3[$];
   int n_chk = 0, n_bad = 0, wc1 = 0, wc3 = 0, exp_hd = 0;
   always #5 clock = ~clock;
   hd_program_loader #(.HD_LATENCY(1)) u_dut1 (
      .clock(clock), .resetCPU(resetCPU), .start(start), .base_addr(base_addr),
      .length(length), .dest_addr(dest_addr), .HDaddress(hd_addr1), .HDIndata(hd_in1),
      .IMwe(imwe1), .IMaddress(ima1), .IMdata(imd1), .busy(busy1), .done(done1),
`ifdef LOADER_CHECKSUM_EN
      .checksum(cks1),
`endif
      .error(err1));
   hd_program_loader #(.HD_LATENCY(3)) u_dut3 (
      .clock(clock), .resetCPU(resetCPU), .start(start), .base_addr(base_addr),
      .length(length), .dest_addr(dest_addr), .HDaddress(hd_addr3), .HDIndata(hd_in3),
      .IMwe(imwe3), .IMaddress(ima3), .IMdata(imd3), .busy(busy3), .done(done3),
`ifdef LOADER_CHECKSUM_EN
      .checksum(cks3),
`endif
      .error(err3));
   // HD read port models with 1 and 3 cycles of latency
   always @(posedge clock) begin
      p1  <= mem[hd_addr1];
      p3a <= mem[hd_addr3];
      p3b <= p3a;
      p3c <= p3b;
   end
   assign hd_in1 = p1;
   assign hd_in3 = p3c;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // IM write scoreboards: every strobe must match the next expected (address, data)
   always @(negedge clock) if (imwe1 === 1'b1) begin
      wc1++;
      if (q1.size() == 0) chk("we1_extra", imwe1, 1'b0);
      else chk("im1", {ima1, imd1}, q1.pop_front());
   end
   always @(negedge clock) if (imwe3 === 1'b1) begin
      wc3++;
      if (q3.size() == 0) chk("we3_extra", imwe3, 1'b0);
      else chk("im3", {ima3, imd3}, q3.pop_front());
   end
   task automatic run(input int b, input int l, input int d);
      bit bad, ok;
      int e1, e3, dk1, dk3, nd1, nd3, nb1, nb3;
      logic [31:0] sum;
      bad = l != 0 && b + l > 4096;
      ok = l != 0 && !bad;
      sum = 0;
      dk1 = 0; dk3 = 0; nd1 = 0; nd3 = 0; nb1 = 0; nb3 = 0;
      if (ok) for (int i = 0; i < l; i++) begin
         q1.push_back({10'((d + i) % 1024), mem[b + i]});
         q3.push_back({10'((d + i) % 1024), mem[b + i]});
         sum += mem[b + i];
      end
      e1 = ok ? 2 + l * 3 : 2;
      e3 = ok ? 2 + l * 5 : 2;
      @(negedge clock);
      start = 1'b1;
      base_addr = 12'(b);
      length = 11'(l);
      dest_addr = 10'(d);
      for (int k = 1; k <= e3 + 2; k++) begin
         @(negedge clock);
         if (k == 1) begin
            chk("err1_clr", err1, 1'b0);
            chk("err3_clr", err3, 1'b0);
         end
         if (done1) begin nd1++; if (dk1 == 0) dk1 = k; end
         if (done3) begin nd3++; if (dk3 == 0) dk3 = k; end
         if (busy1) nb1++;
         if (busy3) nb3++;
         start = ok && k == 3;
         base_addr = 12'($urandom);
         length = 11'($urandom);
         dest_addr = 10'($urandom);
      end
      if (ok) exp_hd = b + l - 1;
      chk("done1_cyc", dk1, e1);
      chk("done3_cyc", dk3, e3);
      chk("done1_n", nd1, 1);
      chk("done3_n", nd3, 1);
      chk("busy1_n", nb1, e1);
      chk("busy3_n", nb3, e3);
      chk("err1", err1, bad);
      chk("err3", err3, bad);
      chk("hd1", hd_addr1, exp_hd);
      chk("hd3", hd_addr3, exp_hd);
      chk("q1_left", q1.size(), 0);
      chk("q3_left", q3.size(), 0);
`ifdef LOADER_CHECKSUM_EN
      chk("sum1", cks1, sum);
      chk("sum3", cks3, sum);
`endif
      q1.delete();
      q3.delete();
   endtask
   initial begin
      int w1, w3;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      resetCPU = 1'b1;
      start = 1'b0;
      base_addr = '0;
      length = '0;
      dest_addr = '0;
      repeat (3) @(negedge clock);
      resetCPU = 1'b0;
      chk("rst_hd", hd_addr1, 0);
      chk("rst_we", imwe1, 0);
      chk("rst_ima", ima1, 0);
      chk("rst_imd", imd1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_err", err1, 0);
      for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + i;
      run(16, 4, 0);
      run(16, 0, 0);
      run(12'hFFE, 3, 5);
      run(12'hFFD, 3, 5);
      run(12'h300, 4, 10'h3FE);
      mem[12'h100] = 32'd1;
      mem[12'h101] = 32'd2;
      mem[12'h102] = 32'hFFFFFFFF;
      run(12'h100, 3, 12'h020);
      // abort during the third word of an eight-word transfer
      q1.push_back({10'd7, mem[12'h200]});
      q1.push_back({10'd8, mem[12'h201]});
      q3.push_back({10'd7, mem[12'h200]});
      w1 = wc1;
      w3 = wc3;
      @(negedge clock);
      start = 1'b1;
      base_addr = 12'h200;
      length = 11'd8;
      dest_addr = 10'd7;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         start = k == 4;
         if (k == 9) resetCPU = 1'b1;
      end
      @(negedge clock);
      resetCPU = 1'b0;
      chk("abort_hd1", hd_addr1, 0);
      chk("abort_hd3", hd_addr3, 0);
      chk("abort_we1", imwe1, 0);
      chk("abort_ima1", ima1, 0);
      chk("abort_imd1", imd1, 0);
      chk("abort_imd3", imd3, 0);
      chk("abort_busy1", busy1, 0);
      chk("abort_busy3", busy3, 0);
      chk("abort_done1", done1, 0);
`ifdef LOADER_CHECKSUM_EN
      chk("abort_sum1", cks1, 0);
`endif
      repeat (20) @(negedge clock);
      chk("abort_wc1", wc1 - w1, 2);
      chk("abort_wc3", wc3 - w3, 1);
      chk("abort_q1", q1.size(), 0);
      chk("abort_q3", q3.size(), 0);
      q1.delete();
      q3.delete();
      exp_hd = 0;
      for (int r = 0; r < 16; r++) begin
         int b, l, d;
         l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
         b = ($urandom_range(0, 3) == 0) ? 4096 - l + int'($urandom_range(0, 2)) : int'($urandom_range(0, 4095));
         if (b > 4095) b = 4095;
         d = int'($urandom_range(0, 1023));
         run(b, l, d);
      end
      run(0, 1024, 5);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
